// File: rtl/key_conditioner_pkg.sv
// Shared types and default timing constants for the synth board input conditioning path.
// The debounce state enum is common to every key cell.
package synth_input_pkg;

    localparam int DEF_NUM_KEYS        = 14;
    localparam int DEF_DEBOUNCE_CYCLES = 10000;
    localparam int DEF_REPEAT_DELAY    = 5000000;
    localparam int DEF_REPEAT_PERIOD   = 1000000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kstate_e;

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the board buttons and the conditioner: raw keys in, clean level/pulse out.
// Free-running level signals, no handshake and no backpressure.
interface key_conditioner_if
    import synth_input_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_pulse;
    logic                any_pressed;

    modport master (output key_raw, input key_level, key_pulse, any_pressed);
    modport slave  (input key_raw, output key_level, key_pulse, any_pressed);
endinterface

// File: rtl/key_debounce_cell.sv
// One key: 2-flop sync + debounce FSM; level/pulse registered DEBOUNCE_CYCLES+1 edges after input settles.
// No backpressure. Auto-repeat pulses only when KEY_COND_REPEAT_EN is defined.
module key_debounce_cell
    import synth_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_raw,
    output logic o_level,
    output logic o_pulse
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          r_s1;
    logic          r_s2;
    kstate_e       r_state;
    kstate_e       w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          r_pulse;
    logic          w_level_nxt;
    logic          w_pulse_nxt;
    logic          w_accept;
    logic          w_rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_key_raw;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_s2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to 1 returns to HELD silently: no second press pulse.
                if (r_s2) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_accept    = (r_state == PRESS_WAIT) && r_s2 && (r_cnt == CNT_LAST);
        w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
        w_pulse_nxt = w_accept || w_rep_fire;
    end

`ifdef KEY_COND_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep;
    logic             r_rep_armed;
    logic [REP_W-1:0] w_rep_target;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; the count only advances while held high.
    assign w_rep_target = r_rep_armed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
    assign w_rep_fire   = (r_state == HELD) && r_s2 && (r_rep == w_rep_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_accept || (r_state == IDLE)) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else if ((r_state == HELD) && r_s2) begin
            if (w_rep_fire) begin
                r_rep       <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rep <= r_rep + 1'b1;
            end
        end
    end
`else
    logic w_unused_repeat;
    assign w_rep_fire      = 1'b0;
    assign w_unused_repeat = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/key_conditioner.sv
// Debounces NUM_KEYS board buttons; level/pulse DEBOUNCE_CYCLES+1 edges after input settles, no backpressure.
// Defining KEY_COND_REPEAT_EN adds per-key auto-repeat pulses while a key is held.
module key_conditioner
    import synth_input_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    key_conditioner_if.slave  io
);
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_pulse;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_key_raw (io.key_raw[gi]),
            .o_level   (w_level[gi]),
            .o_pulse   (w_pulse[gi])
        );
    end

    assign io.key_level   = w_level;
    assign io.key_pulse   = w_pulse;
    assign io.any_pressed = |w_level;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: table rows, hand-written corner sequences and random keys vs a window-based model.
module tb_key_conditioner;
    localparam int NK = 4;
    localparam int DB = 8;
    localparam int RD = 20;
    localparam int RP = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_conditioner_if #(.NUM_KEYS(NK)) io ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int t_step   = 0;
    int plog[NK][$];

    // Model: a key's level flips once the last DB synchronized samples all disagree with it.
    logic [NK-1:0] h[$];
    logic [NK-1:0] m_level;
    logic [NK-1:0] m_pulse;
    int            m_held[NK];

    typedef struct {
        string       name;
        int          key;
        logic [31:0] pat;
        int          plen;
        int          run;
        int          exp_cnt;
        int          exp_first;
        logic        exp_level;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic hbit(input int back, input int k);
        int idx;
        idx = h.size() - 1 - back;
        if (idx < 0) return 1'b0;
        return h[idx][k];
    endfunction

    function automatic int first_pulse(input int k);
        if (plog[k].size() == 0) return -1;
        return plog[k][0];
    endfunction

    task automatic model_reset();
        h.delete();
        m_level = '0;
        m_pulse = '0;
        for (int k = 0; k < NK; k++) m_held[k] = 0;
    endtask

    task automatic model_edge(input logic [NK-1:0] raw);
        logic cur, prev, opp;
        h.push_back(raw);
        if (h.size() > 16) void'(h.pop_front());
        m_pulse = '0;
        for (int k = 0; k < NK; k++) begin
            cur  = hbit(2, k);
            prev = hbit(3, k);
            if (m_level[k] && prev && cur) begin
                m_held[k]++;
`ifdef KEY_COND_REPEAT_EN
                if (m_held[k] == RD || (m_held[k] > RD && ((m_held[k] - RD) % RP) == 0))
                    m_pulse[k] = 1'b1;
`endif
            end
            opp = 1'b1;
            for (int j = 0; j < DB; j++)
                if (hbit(2 + j, k) == m_level[k]) opp = 1'b0;
            if (opp) begin
                if (!m_level[k]) begin
                    m_level[k] = 1'b1;
                    m_pulse[k] = 1'b1;
                    m_held[k]  = 0;
                end else begin
                    m_level[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic [NK-1:0] raw);
        io.key_raw = raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
        chk("key_level", int'(io.key_level), int'(m_level));
        chk("key_pulse", int'(io.key_pulse), int'(m_pulse));
        chk("any_pressed", int'(io.any_pressed), int'(|m_level));
        for (int k = 0; k < NK; k++)
            if (io.key_pulse[k]) plog[k].push_back(t_step);
        t_step++;
    endtask

    // Called at a falling edge; key_raw is left as the caller set it.
    task automatic do_reset(input int hold_cycles);
        rst = 1'b1;
        #1;
        chk("rst_level", int'(io.key_level), 0);
        chk("rst_pulse", int'(io.key_pulse), 0);
        chk("rst_any", int'(io.any_pressed), 0);
        model_reset();
        repeat (hold_cycles) @(negedge clk);
        rst    = 1'b0;
        t_step = 0;
        for (int k = 0; k < NK; k++) plog[k].delete();
    endtask

    initial begin
        logic [NK-1:0] raw;
        logic [NK-1:0] rr;
        int            run_left[NK];
        int            fall;
        int            held_all;
        int            exp_rep[$];

        tbl[0] = '{"clean_press",   0, 32'h1,  1, 20, 1,  9, 1'b1};
        tbl[1] = '{"press_bounce",  1, 32'h2D, 6, 30, 1, 14, 1'b1};
        tbl[2] = '{"glitch_7",      2, 32'h7F, 8, 20, 0, -1, 1'b0};
        tbl[3] = '{"exact_8_press", 2, 32'hFF, 9, 30, 1,  9, 1'b0};
        tbl[4] = '{"not_yet",       3, 32'h1,  1,  9, 0, -1, 1'b0};

        io.key_raw = '0;
        model_reset();
        @(negedge clk);
        do_reset(2);

        for (int r = 0; r < 5; r++) begin
            io.key_raw = '0;
            do_reset(2);
            for (int s = 0; s < tbl[r].run; s++) begin
                raw = '0;
                raw[tbl[r].key] = (s < tbl[r].plen) ? tbl[r].pat[s] : tbl[r].pat[tbl[r].plen - 1];
                step(raw);
            end
            chk({tbl[r].name, "_cnt"}, plog[tbl[r].key].size(), tbl[r].exp_cnt);
            chk({tbl[r].name, "_first"}, first_pulse(tbl[r].key), tbl[r].exp_first);
            chk({tbl[r].name, "_level"}, int'(io.key_level[tbl[r].key]), int'(tbl[r].exp_level));
        end

        // Release bounce on key 2: three low cycles are absorbed, a stable low drops the level.
        io.key_raw = '0;
        do_reset(2);
        repeat (12) step(4'b0100);
        held_all = 1;
        repeat (3) begin step(4'b0000); if (!io.key_level[2]) held_all = 0; end
        repeat (5) begin step(4'b0100); if (!io.key_level[2]) held_all = 0; end
        fall = -1;
        for (int s = 0; s < 12; s++) begin
            int ts;
            ts = t_step;
            step(4'b0000);
            if (fall < 0 && !io.key_level[2]) fall = ts;
        end
        chk("relbounce_held", held_all, 1);
        chk("relbounce_pulses", plog[2].size(), 1);
        chk("relbounce_fall", fall, 29);

        // Keys 0 and 3 pressed together.
        io.key_raw = '0;
        do_reset(2);
        repeat (12) step(4'b1001);
        chk("simul_k0", first_pulse(0), 9);
        chk("simul_k3", first_pulse(3), 9);
        chk("simul_cnt", plog[0].size() + plog[3].size(), 2);
        chk("simul_others", int'(io.key_level[2:1]), 0);

        // Reset at cnt=5 with key 0 held, then again while HELD.
        io.key_raw = '0;
        do_reset(2);
        repeat (7) step(4'b0001);
        do_reset(2);
        repeat (12) step(4'b0001);
        chk("rst_mid_first", first_pulse(0), 9);
        chk("rst_mid_held", int'(io.key_level[0]), 1);
        do_reset(3);
        repeat (10) step(4'b0001);
        chk("rst_held_first", first_pulse(0), 9);
        chk("rst_held_cnt", plog[0].size(), 1);

        // Long hold: auto-repeat schedule.
`ifdef KEY_COND_REPEAT_EN
        exp_rep = '{9, 29, 39, 49, 59};
`else
        exp_rep = '{9};
`endif
        io.key_raw = '0;
        do_reset(2);
        repeat (69) step(4'b0001);
        chk("repeat_cnt", plog[0].size(), exp_rep.size());
        for (int i = 0; i < exp_rep.size() && i < plog[0].size(); i++)
            chk("repeat_time", plog[0][i], exp_rep[i]);

        // Random bouncy keys against the model, with a reset in the middle.
        io.key_raw = '0;
        do_reset(2);
        rr = '0;
        for (int k = 0; k < NK; k++) run_left[k] = 0;
        for (int s = 0; s < 2400; s++) begin
            for (int k = 0; k < NK; k++) begin
                if (run_left[k] == 0) begin
                    rr[k] = ~rr[k];
                    run_left[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60))
                                                              : int'($urandom_range(1, 12));
                end
                run_left[k]--;
            end
            step(rr);
            if (s == 1200) do_reset(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
